// File: rtl/qs_sort_pkg.sv
// qs_sort_pkg: shared types and the sort-order helper for the qs_sort_n packet sorter.
//   state_t    - controller states (IDLE, LOAD, EMIT)
//   precedes() - true when an incoming word must be placed ahead of a stored word
package qs_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // The comparison is strict, so an equal key never precedes the stored word.
  // The new word therefore lands after earlier equal words, which keeps the sort stable.
  // lt/gt compare the new word against the stored word. dsc=1 selects descending order.
  function automatic logic precedes(input logic lt, input logic gt, input logic dsc);
    return dsc ? gt : lt;
  endfunction

endpackage

// File: rtl/qs_sort_cell.sv
// qs_sort_cell: one slot of the parallel insertion array.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   i_dsc     - active sort mode (1 = descending)
//   i_new     - incoming word (write data, compare operand)
//   i_below   - word held by the slot one position lower (shift source)
//   i_ins     - load i_new into this slot
//   i_shift   - load i_below into this slot
//   o_word    - registered slot contents
//   o_prec    - incoming word precedes this slot's word under the active mode
module qs_sort_cell
  import qs_sort_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_dsc,
  input  logic [W-1:0] i_new,
  input  logic [W-1:0] i_below,
  input  logic         i_ins,
  input  logic         i_shift,
  output logic [W-1:0] o_word,
  output logic         o_prec
);

  logic [W-1:0] r_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
    end else if (i_ins) begin
      r_word <= i_new;
    end else if (i_shift) begin
      r_word <= i_below;
    end
  end

  assign o_word = r_word;
  assign o_prec = precedes(i_new < r_word, i_new > r_word, i_dsc);

endmodule

// File: rtl/qs_sort_n.sv
// qs_sort_n: sorts one packet of up to N unsigned W-bit words and streams it out in order.
// Each input beat is inserted in a single cycle. The new word is compared in parallel
// against every occupied slot, and the slots that follow the insertion point shift up.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_vld/in_sop/in_eop     - input beat framing
//   in_dsc                   - sort mode, taken from the sop beat (1 = descending)
//   in_dat                   - input word
//   in_rdy                   - low only while the sorted packet is being emitted
//   out_vld_r/sop_r/eop_r    - registered output framing, no backpressure
//   out_err_r                - packet error (overflow or repeated sop), valid with out_eop_r
//   out_dat_r                - sorted word
// Optional build macro QS_SORT_STATS_EN adds these saturating counters:
//   stat_pkt_r  - packets emitted
//   stat_err_r  - packets emitted with an error
//   stat_drop_r - stray non-sop beats discarded while idle
module qs_sort_n
  import qs_sort_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic         in_dsc,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld_r,
  output logic         out_sop_r,
  output logic         out_eop_r,
  output logic         out_err_r,
`ifdef QS_SORT_STATS_EN
  output logic [31:0]  stat_pkt_r,
  output logic [31:0]  stat_err_r,
  output logic [15:0]  stat_drop_r,
`endif
  output logic [W-1:0] out_dat_r
);

  state_t           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_idx, w_idx_d;
  logic             r_dsc, w_dsc_d;
  logic             r_err, w_err_d;

  logic             w_acc, w_start, w_full, w_ins_load, w_last;
  logic [CNT_W-1:0] w_pos;
  logic [W-1:0]     w_slot [N];
  logic [N-1:0]     w_prec_raw, w_occ_prec, w_ins, w_shift;
  logic [W-1:0]     w_rd_word;
  logic             w_vld_d, w_sop_d, w_eop_d, w_oerr_d;

  assign in_rdy     = (r_state != EMIT);
  assign w_acc      = in_vld & in_rdy;
  assign w_start    = w_acc & (r_state == IDLE) & in_sop;
  assign w_full     = (r_cnt == CNT_W'(N));
  assign w_ins_load = w_acc & (r_state == LOAD) & ~w_full;
  assign w_last     = (r_idx == r_cnt - CNT_W'(1));

  // Slot array. Slot 0 never takes a shift, so its shift source is tied off.
  for (genvar g = 0; g < int'(N); g++) begin : g_cell
    logic [W-1:0] w_below;
    if (g == 0) begin : g_bottom
      assign w_below  = '0;
      assign w_ins[g] = w_start | (w_ins_load & (w_pos == '0));
    end else begin : g_upper
      assign w_below  = w_slot[g-1];
      assign w_ins[g] = w_ins_load & (w_pos == CNT_W'(g));
    end
    assign w_shift[g]    = w_ins_load & (CNT_W'(g) > w_pos) & (CNT_W'(g) <= r_cnt);
    assign w_occ_prec[g] = w_prec_raw[g] & (CNT_W'(g) < r_cnt);

    qs_sort_cell #(
      .W (W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_dsc   (r_dsc),
      .i_new   (in_dat),
      .i_below (w_below),
      .i_ins   (w_ins[g]),
      .i_shift (w_shift[g]),
      .o_word  (w_slot[g]),
      .o_prec  (w_prec_raw[g])
    );
  end

  // The lowest occupied slot that the new word precedes is the insertion point.
  // If there is no such slot, the word is appended at r_cnt.
  always_comb begin
    w_pos = r_cnt;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_occ_prec[i]) begin
        w_pos = CNT_W'(i);
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_idx == CNT_W'(i)) begin
        w_rd_word = w_slot[i];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_dsc_d   = r_dsc;
    w_err_d   = r_err;
    w_vld_d   = 1'b0;
    w_sop_d   = 1'b0;
    w_eop_d   = 1'b0;
    w_oerr_d  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_idx_d = '0;
        if (w_start) begin
          w_dsc_d   = in_dsc;
          w_err_d   = 1'b0;
          w_cnt_d   = CNT_W'(1);
          w_state_d = in_eop ? EMIT : LOAD;
        end
      end
      LOAD: begin
        w_idx_d = '0;
        if (w_acc) begin
          if (in_sop || w_full) begin
            w_err_d = 1'b1;
          end
          if (!w_full) begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
          if (in_eop) begin
            w_state_d = EMIT;
          end
        end
      end
      EMIT: begin
        w_vld_d  = 1'b1;
        w_sop_d  = (r_idx == '0);
        w_eop_d  = w_last;
        w_oerr_d = w_last & r_err;
        if (w_last) begin
          w_state_d = IDLE;
        end else begin
          w_idx_d = r_idx + CNT_W'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dsc   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_dsc   <= w_dsc_d;
      r_err   <= w_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_r <= 1'b0;
      out_sop_r <= 1'b0;
      out_eop_r <= 1'b0;
      out_err_r <= 1'b0;
      out_dat_r <= '0;
    end else begin
      out_vld_r <= w_vld_d;
      out_sop_r <= w_sop_d;
      out_eop_r <= w_eop_d;
      out_err_r <= w_oerr_d;
      if (w_vld_d) begin
        out_dat_r <= w_rd_word;
      end
    end
  end

`ifdef QS_SORT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pkt_r  <= '0;
      stat_err_r  <= '0;
      stat_drop_r <= '0;
    end else begin
      if (w_eop_d && (stat_pkt_r != '1)) begin
        stat_pkt_r <= stat_pkt_r + 32'd1;
      end
      if (w_oerr_d && (stat_err_r != '1)) begin
        stat_err_r <= stat_err_r + 32'd1;
      end
      if (w_acc && (r_state == IDLE) && !in_sop && (stat_drop_r != '1)) begin
        stat_drop_r <= stat_drop_r + 16'd1;
      end
    end
  end
`endif

endmodule
